// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer driving an external ALU from a 16-bit instruction stream.
// Define SEQ_TRAP_EN to trap on reserved opcodes; otherwise they execute as NOP.
module instr_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    output logic                   imem_req,
    output logic [DATA_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [4:0]             alu_opcode,
    output logic [DATA_WIDTH-1:0]  alu_operand1,
    output logic [DATA_WIDTH-1:0]  alu_operand2,
    output logic [DATA_WIDTH-1:0]  alu_param,
    input  logic [DATA_WIDTH-1:0]  alu_result,
    input  logic [2:0]             alu_status,
    output logic [DATA_WIDTH-1:0]  pc_out,
    output logic [DATA_WIDTH-1:0]  acc_out,
    output logic [2:0]             flags_out,
    output logic                   busy,
    output logic                   trap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_TRAP
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_VAL  = 5'h09;
    localparam logic [4:0] OP_GOTO = 5'h10;
    localparam logic [4:0] OP_IFZ  = 5'h11;
    localparam logic [4:0] OP_IFNZ = 5'h12;
    localparam logic [4:0] OP_IFEQ = 5'h13;
    localparam logic [4:0] OP_IFST = 5'h14;
    localparam logic [4:0] OP_IFGT = 5'h15;

    state_t                state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] acc;
    logic [2:0]            flags;
    logic [4:0]            ir_op;
    logic [DATA_WIDTH-1:0] ir_par;

    logic [4:0]            fetch_op;
    logic                  fetch_alu;
    logic                  op_alu;
    logic [DATA_WIDTH-1:0] pc_inc;
    logic [DATA_WIDTH-1:0] exec_pc;
    logic [DATA_WIDTH-1:0] exec_acc;
    logic [2:0]            exec_flags;
    logic                  rsvd_unused;

    assign fetch_op  = imem_data[INSTR_WIDTH-1 -: 5];
    assign fetch_alu = (fetch_op >= 5'h01) && (fetch_op <= 5'h08);
    assign op_alu    = (ir_op >= 5'h01) && (ir_op <= 5'h08);

    // Bits between opcode and param carry no meaning.
    assign rsvd_unused = ^imem_data[INSTR_WIDTH-6:DATA_WIDTH];

    assign imem_addr    = pc;
    assign pc_out       = pc;
    assign acc_out      = acc;
    assign flags_out    = flags;
    assign alu_operand1 = acc;
    assign alu_operand2 = ir_par;
    assign alu_param    = ir_par;

    always_comb begin
        pc_inc     = pc + DATA_WIDTH'(1);
        exec_pc    = pc_inc;
        exec_acc   = acc;
        exec_flags = flags;
        unique case (1'b1)
            op_alu: begin
                exec_acc   = alu_result;
                exec_flags = alu_status;
            end
            (ir_op == OP_VAL):  exec_acc = ir_par;
            (ir_op == OP_GOTO): exec_pc  = ir_par;
            (ir_op == OP_IFZ):  if (flags[2]) exec_pc = ir_par;
            (ir_op == OP_IFNZ): if (!flags[2]) exec_pc = ir_par;
            (ir_op == OP_IFEQ): if (acc == ir_par) exec_pc = ir_par;
            (ir_op == OP_IFST): if (acc < ir_par) exec_pc = ir_par;
            (ir_op == OP_IFGT): if (acc > ir_par) exec_pc = ir_par;
            default: ;
        endcase
    end

`ifdef SEQ_TRAP_EN
    logic trap_q;
    logic op_rsvd;

    assign op_rsvd = ((ir_op >= 5'h0A) && (ir_op <= 5'h0F)) ||
                     (ir_op >= 5'h16);
    assign trap    = trap_q;
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            acc        <= '0;
            flags      <= '0;
            ir_op      <= '0;
            ir_par     <= '0;
            imem_req   <= 1'b0;
            busy       <= 1'b0;
            alu_opcode <= OP_NOP;
`ifdef SEQ_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        state      <= S_EXEC;
                        imem_req   <= 1'b0;
                        ir_op      <= fetch_op;
                        ir_par     <= imem_data[DATA_WIDTH-1:0];
                        alu_opcode <= fetch_alu ? fetch_op : OP_NOP;
                    end
                end
                S_EXEC: begin
                    alu_opcode <= OP_NOP;
`ifdef SEQ_TRAP_EN
                    if (op_rsvd) begin
                        state  <= S_TRAP;
                        busy   <= 1'b0;
                        trap_q <= 1'b1;
                    end else
`endif
                    begin
                        pc    <= exec_pc;
                        acc   <= exec_acc;
                        flags <= exec_flags;
                        if (run) begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_TRAP: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of accumulator, param, PC and ALU data ports.
REQ-002 SHALL have parameter INSTR_WIDTH, default 16: instruction word width; opcode [15:11], reserved [10:8], param [7:0].
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 run  in  1  1 = fetch/execute permitted; sampled in IDLE and at end of EXEC.
REQ-006 imem_req  out  1  instruction fetch request.
REQ-007 imem_addr  out  8  fetch address, equals PC.
REQ-008 imem_ack  in  1  fetch complete; imem_data valid in the same cycle.
REQ-009 imem_data  in  16  instruction word.
REQ-010 alu_opcode  out  5  opcode driven to the ALU.
REQ-011 alu_operand1 / alu_operand2 / alu_param  out  8 each  ACC / IR param / IR param.
REQ-012 alu_result  in  8  combinational ALU result.
REQ-013 alu_status  in  3  ALU status: bit0 carry, bit1 underflow, bit2 zero.
REQ-014 pc_out / acc_out  out  8 each  current PC / accumulator.
REQ-015 flags_out  out  3  registered flags, same bit order as alu_status.
REQ-016 busy  out  1  1 in FETCH or EXEC.
REQ-017 trap  out  1  reserved opcode trapped.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, EXEC, TRAP.
REQ-019 IDLE: run=1 -> FETCH next cycle; else stay.
REQ-020 FETCH: imem_req=1, imem_addr=PC; on imem_ack=1 latch imem_data into IR, go EXEC; else hold request, stay.
REQ-021 EXEC SHALL last exactly one cycle; minimum instruction latency is 2 cycles (ack in first FETCH cycle).
REQ-022 alu_opcode SHALL equal IR opcode only in EXEC for opcodes 0x01-0x08, else 0x00 (NOP).
REQ-023 ADD, SUB, AND, OR, NOT, XOR, SHL, SHR (0x01-0x08): at end of EXEC ACC <= alu_result, FLAGS <= alu_status, PC <= PC+1.
REQ-024 NOP (0x00): ACC, FLAGS unchanged; PC <= PC+1.
REQ-025 VAL (0x09): ACC <= param; FLAGS unchanged; PC <= PC+1.
REQ-026 GOTO (0x10): PC <= param.
REQ-027 IFZ (0x11)/IFNZ (0x12): PC <= param if FLAGS[2] is 1/0 respectively, else PC+1.
REQ-028 IFEQ (0x13)/IFST (0x14)/IFGT (0x15): PC <= param if ACC ==/</> param (unsigned), else PC+1; FLAGS unchanged.
REQ-029 Branches SHALL never modify ACC or FLAGS.
REQ-030 PC arithmetic SHALL be modulo 256; 0xFF+1 = 0x00.
REQ-031 Reserved opcodes (0x0A-0x0F, 0x16-0x1F): per REQ-037/038.
REQ-032 After EXEC: run=1 -> FETCH; run=0 -> IDLE; run deassertion SHALL NOT abort FETCH or EXEC in progress.
REQ-033 TRAP: trap=1, imem_req=0, PC/ACC/FLAGS frozen; exit only by reset.

Reset
REQ-034 reset=1 at a rising edge SHALL force IDLE, PC=0, ACC=0, FLAGS=000, IR=0, trap=0, busy=0, imem_req=0, alu_opcode=0, in any state including mid-FETCH with pending ack.
REQ-035 imem_ack arriving in the reset cycle SHALL be ignored.
REQ-036 Reset SHALL take priority over run and imem_ack.

Configuration
REQ-037 With macro SEQ_TRAP_EN defined: reserved opcode in EXEC -> TRAP next cycle, PC not incremented, trap=1.
REQ-038 Without SEQ_TRAP_EN: reserved opcode executes as NOP (PC+1, ACC/FLAGS unchanged); trap tied 0; TRAP state unreachable.

Verification
REQ-039 Reset, run=1, mem[0]=VAL 0x05, mem[1]=ADD 0xFB, ack immediate -> after 4 cycles ACC=0x00, FLAGS=101, PC=0x02.
REQ-040 ACC=0x03, SUB 0x05 -> ACC=0xFE, FLAGS=010; then IFNZ 0x40 -> PC=0x40.
REQ-041 PC=0xFF, NOP -> PC=0x00; GOTO 0x10 -> PC=0x10, ACC/FLAGS unchanged.
REQ-042 imem_ack delayed 3 cycles -> imem_req held 3 cycles with stable imem_addr; reset asserted in 2nd wait cycle -> IDLE, PC=0, imem_req=0 next cycle.
REQ-043 Opcode 0x0A: with SEQ_TRAP_EN -> trap=1, PC frozen, stays until reset; without -> PC+1, trap=0.
REQ-044 ACC=0x20: IFGT 0x1F branches to 0x1F; IFST 0x1F and IFEQ 0x1F fall through to PC+1.
